jtframe_cen_monitor: RTL

//  Checks a clock-enable pulse stream against its programmed fraction n/m.

---
 rtl/jtframe_cen_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/jtframe_cen_monitor.sv
// Receive-side checker for a fractional clock-enable stream: measures pulses per
// window of (m<<K) base ticks and flags pulse-to-pulse gaps outside floor/ceil(m/n).
module jtframe_cen_monitor #(
  parameter int K   = 4,
  parameter int TOL = 2,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cen_in,
  input  logic          cen,
  input  logic [9:0]    n,
  input  logic [9:0]    m,
  output logic [CW-1:0] meas_cnt,
  output logic          meas_valid,
  output logic          rate_ok,
  output logic          too_fast,
  output logic          too_slow,
  output logic          gap_err,
  output logic          cfg_err
);

  localparam int GW = 12;
  localparam logic [CW+1:0] TOL_W = (CW+2)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t state, state_next;

  logic [9:0]    n_r, m_r, n_d, m_d;
  logic          cfg_valid;
  logic          cfg_bad, cfg_ok, cfg_chg;

  logic [CW-1:0] tick, cnt, cnt_next, win_len;
  logic          win_end;

  logic [GW-1:0] gacc, gacc_next, gacc_sat;
  logic [GW:0]   g_ext, n_ext, m_ext, gacc_sum;
  logic          gap_long, gap_short, gap_hit, gap_flag;

  logic [CW+1:0] cnt_w, exp_w;
  logic          fast_now, slow_now;

  logic          arm_start, run, load;

  // cfg_valid keeps cfg_err low until n/m have been captured at least once after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r       <= '0;
      m_r       <= '0;
      n_d       <= '0;
      m_d       <= '0;
      cfg_valid <= 1'b0;
    end else begin
      n_r       <= n;
      m_r       <= m;
      n_d       <= n_r;
      m_d       <= m_r;
      cfg_valid <= 1'b1;
    end
  end

  assign cfg_bad = (n_r == 10'd0) || (m_r == 10'd0) || (n_r > m_r);
  assign cfg_ok  = cfg_valid && !cfg_bad;
  assign cfg_chg = (n_r != n_d) || (m_r != m_d);
  assign cfg_err = cfg_valid && cfg_bad;

  assign win_len  = CW'(m_r) << K;
  assign win_end  = cen_in && (tick == win_len - CW'(1));
  assign cnt_next = (cen && (cnt != '1)) ? cnt + CW'(1) : cnt;

  // gacc holds g*n for the gap in progress; compared before this clock's tick is added
  assign g_ext     = {1'b0, gacc};
  assign n_ext     = (GW+1)'(n_r);
  assign m_ext     = (GW+1)'(m_r);
  assign gacc_sum  = g_ext + n_ext;
  assign gacc_sat  = gacc_sum[GW] ? '1 : gacc_sum[GW-1:0];
  assign gap_long  = g_ext >= (m_ext + n_ext);
  assign gap_short = (g_ext + n_ext) <= m_ext;
  assign gap_hit   = cen && (gap_long || gap_short);

  always_comb begin
    gacc_next = gacc;
    if (cen)
      gacc_next = cen_in ? GW'(n_r) : '0;
    else if (cen_in)
      gacc_next = gacc_sat;
  end

  assign cnt_w    = (CW+2)'(cnt_next);
  assign exp_w    = (CW+2)'(n_r) << K;
  assign fast_now = cnt_w > (exp_w + TOL_W);
  assign slow_now = (cnt_w + TOL_W) < exp_w;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Losing enable or a valid config abandons the window; a config change re-arms it
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable && cfg_ok) state_next = ARM;
      end
      ARM: begin
        if (!enable || !cfg_ok) state_next = IDLE;
        else if (cfg_chg)       state_next = ARM;
        else if (cen)           state_next = MEASURE;
      end
      MEASURE: begin
        if (!enable || !cfg_ok) state_next = IDLE;
        else if (cfg_chg)       state_next = ARM;
        else if (win_end)       state_next = REPORT;
      end
      REPORT: begin
        if (!enable || !cfg_ok) state_next = IDLE;
        else if (cfg_chg)       state_next = ARM;
        else                    state_next = MEASURE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    meas_valid = (state == REPORT);
    arm_start  = (state == ARM) && (state_next == MEASURE);
    run        = (state == MEASURE) || (state == REPORT);
    load       = (state == MEASURE) && (state_next == REPORT);
  end

  // Results are captured on the final tick so they are already valid while meas_valid is high
  always_ff @(posedge clk) begin
    if (rst) begin
      tick     <= '0;
      cnt      <= '0;
      gacc     <= '0;
      gap_flag <= 1'b0;
      meas_cnt <= '0;
      rate_ok  <= 1'b0;
      too_fast <= 1'b0;
      too_slow <= 1'b0;
      gap_err  <= 1'b0;
    end else if (arm_start) begin
      tick     <= '0;
      cnt      <= CW'(1);
      gacc     <= cen_in ? GW'(n_r) : '0;
      gap_flag <= 1'b0;
    end else if (run) begin
      gacc <= gacc_next;
      if (state == REPORT) begin
        tick     <= '0;
        cnt      <= {{(CW-1){1'b0}}, cen};
        gap_flag <= gap_flag || gap_hit;
      end else begin
        if (cen_in) tick <= tick + CW'(1);
        cnt <= cnt_next;
        if (load) begin
          meas_cnt <= cnt_next;
          too_fast <= fast_now;
          too_slow <= slow_now;
          rate_ok  <= !fast_now && !slow_now;
          gap_err  <= gap_flag || gap_hit;
          gap_flag <= 1'b0;
        end else begin
          gap_flag <= gap_flag || gap_hit;
        end
      end
    end
  end

endmodule
